// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, diff = a - b (mod 2^W), LSB first, one bit per clock.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     start  request, sampled only in IDLE
//     a, b   W-bit minuend / subtrahend, captured when start is accepted
//     busy   high while bits are being processed (SHIFT)
//     done   single-cycle pulse; diff/bout valid from this cycle
//     diff   result a - b mod 2^W, held until the next done or reset
//     bout   final borrow, 1 iff a < b unsigned
//     ovf    signed overflow flag, present only when SERIAL_SUB_OVF_EN is defined
module serial_sub #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_res;
  logic           r_br;
  logic [CW-1:0]  r_cnt;
  logic           w_d;
  logic           w_br_next;
  logic           w_last;
  logic [W-1:0]   w_res_next;
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_last    = r_cnt == CW'(W - 1);
  // The new difference bit enters at the MSB so that after W shifts bit 0 sits at the LSB.
  generate
    if (W == 1) begin : g_one
      assign w_res_next = w_d;
    end else begin : g_many
      assign w_res_next = {w_d, r_res[W-1:1]};
    end
  endgenerate
`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are shifted away during SHIFT, so their signs are kept separately.
  logic r_sa;
  logic r_sb;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            r_sa    <= a[W-1];
            r_sb    <= b[W-1];
`endif
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + 1'b1;
          // The last bit is produced this cycle, so outputs load the next-state values directly.
          if (w_last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= w_res_next;
            bout    <= w_br_next;
            r_state <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= (r_sa != r_sb) && (w_res_next[W-1] != r_sa);
`endif
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
